// File: rtl/stack_pkg.sv
// Shared constants and operation encoding for the stack store slice.
package stack_pkg;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned COUNT_W = 3;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_WRITE,
    OP_READ,
    OP_CONFLICT
  } op_e;

endpackage

// File: rtl/stack_ram.sv
// 4-entry register file: synchronous write, registered read, combinational peek.
module stack_ram
  import stack_pkg::*;
#(
  parameter int unsigned DATA_W = WIDTH
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o,
  input  logic [ADDR_W-1:0] paddr_i,
  output logic [DATA_W-1:0] pdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (we_i) begin
        mem_q[waddr_i] <= wdata_i;
      end
      // Read port holds its last value between reads.
      if (re_i) begin
        rdata_q <= mem_q[raddr_i];
      end
    end
  end

  assign rdata_o = rdata_q;
  assign pdata_o = mem_q[paddr_i];

endmodule

// File: rtl/stack_store.sv
// Stack storage stage: executes push/pop from the pointer stage and checks it.
module stack_store #(
  parameter int unsigned WIDTH = stack_pkg::WIDTH,
  parameter int unsigned DEPTH = stack_pkg::DEPTH
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             A0,
  input  logic             A1,
  input  logic             push,
  input  logic             pop,
  input  logic             O,
  input  logic             U,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Dout,
  output logic             Dout_valid,
  output logic [WIDTH-1:0] Top,
  output logic [2:0]       Count,
  output logic             Err
);

  localparam int unsigned AW = stack_pkg::ADDR_W;
  localparam int unsigned CW = stack_pkg::COUNT_W;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [AW-1:0]    addr;
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic             we, re;
  logic [WIDTH-1:0] peek;
  stack_pkg::op_e   op;

  assign addr = {A1, A0};

  always_comb begin
    op = stack_pkg::OP_IDLE;
    if (push && pop) begin
      op = stack_pkg::OP_CONFLICT;
    end else if (push && !O) begin
      op = stack_pkg::OP_WRITE;
    end else if (pop && !U) begin
      op = stack_pkg::OP_READ;
    end
  end

  // Address mismatches flag an error but the operation still executes;
  // full/empty violations flag an error and are dropped.
  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    valid_d = 1'b0;
    we      = 1'b0;
    re      = 1'b0;
    unique case (op)
      stack_pkg::OP_CONFLICT: err_d = 1'b1;
      stack_pkg::OP_WRITE: begin
        if (count_q == FULL) begin
          err_d = 1'b1;
        end else begin
          we      = 1'b1;
          count_d = count_q + ONE;
          if (CW'(addr) != count_q) err_d = 1'b1;
        end
      end
      stack_pkg::OP_READ: begin
        if (count_q == '0) begin
          err_d = 1'b1;
        end else begin
          re      = 1'b1;
          valid_d = 1'b1;
          count_d = count_q - ONE;
          if (CW'(addr) != count_q - ONE) err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      count_q <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  stack_ram #(
    .DATA_W(WIDTH)
  ) u_ram (
    .clk_i  (Clk),
    .rst_ni (Rst_n),
    .we_i   (we),
    .waddr_i(addr),
    .wdata_i(Din),
    .re_i   (re),
    .raddr_i(addr),
    .rdata_o(Dout),
    .paddr_i(AW'(count_q - ONE)),
    .pdata_o(peek)
  );

  assign Top        = (count_q != '0) ? peek : '0;
  assign Count      = count_q;
  assign Err        = err_q;
  assign Dout_valid = valid_q;

endmodule
